// File: rtl/hazard_scoreboard.sv
// Issue-side register scoreboard: per-register forwarding countdowns, stall and
// bubble generation toward ID/EX, and a saturating hazard-stall cycle counter.
module hazard_scoreboard #(
  parameter int NREGS    = 32,
  parameter int LAT_W    = 2,
  parameter int CNT_W    = 16,
  parameter int ZERO_REG = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IssueValidIN,
  input  logic [4:0]       DirAIN,
  input  logic [4:0]       DirBIN,
  input  logic             UsaAIN,
  input  logic             UsaBIN,
  input  logic             WriteRegIN,
  input  logic [4:0]       DirWriteIN,
  input  logic [LAT_W-1:0] LatIN,
  input  logic             StallExtIN,
  input  logic             FlushIN,
  output logic             StallOUT,
  output logic             BubbleOUT,
  output logic [CNT_W-1:0] StallCntOUT,
  output logic [NREGS-1:0] PendOUT
);

  logic [LAT_W-1:0] cnt_q [NREGS];
  logic [LAT_W-1:0] cnt_d [NREGS];
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;
  logic [NREGS-1:0] pend;
  logic [31:0]      pend_ext;
  logic             haz_a;
  logic             haz_b;
  logic             haz_w;
  logic             hazard;
  logic             issue;

  function automatic logic tracked(input logic [4:0] addr);
    return !((ZERO_REG != 0) && (addr == 5'd0));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    pend = '0;
    for (int r = 0; r < NREGS; r++) begin
      pend[r] = (cnt_q[r] != '0);
    end
  end

  // Address lookups go through a 32-wide view so any 5-bit address is in range.
  assign pend_ext = 32'(pend);

  always_comb begin
    haz_a  = UsaAIN     & tracked(DirAIN)     & pend_ext[DirAIN];
    haz_b  = UsaBIN     & tracked(DirBIN)     & pend_ext[DirBIN];
    haz_w  = WriteRegIN & tracked(DirWriteIN) & pend_ext[DirWriteIN];
    hazard = IssueValidIN & ~FlushIN & (haz_a | haz_b | haz_w);
    issue  = IssueValidIN & ~FlushIN & ~hazard & ~StallExtIN;
  end

  assign StallOUT    = hazard | StallExtIN;
  assign BubbleOUT   = (hazard | FlushIN) & ~StallExtIN;
  assign StallCntOUT = stall_cnt_q;
  assign PendOUT     = pend;

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (issue && WriteRegIN && (DirWriteIN == 5'(r)) && tracked(5'(r))) begin
        cnt_d[r] = LatIN;
      end else if ((cnt_q[r] != '0) && !StallExtIN) begin
        cnt_d[r] = cnt_q[r] - LAT_W'(1);
      end
    end
    stall_cnt_d = hazard ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a per-register countdown model is
// compared against the DUT every cycle, plus hand-computed literal checks.
module tb_hazard_scoreboard;

  localparam int NREGS  = 32;
  localparam int LAT_W  = 2;
  localparam int CNT_W  = 4;
  localparam int CNTMAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             iv = 1'b0, ua = 1'b0, ub = 1'b0, wr = 1'b0, ext = 1'b0, fl = 1'b0;
  logic [4:0]       da = '0, db = '0, dw = '0;
  logic [LAT_W-1:0] lat = '0;
  logic             stall_o, bubble_o;
  logic [CNT_W-1:0] scnt_o;
  logic [NREGS-1:0] pend_o;

  int n_vec = 0;
  int n_err = 0;

  int mcnt [NREGS];
  int mstall;

  hazard_scoreboard #(.NREGS(NREGS), .LAT_W(LAT_W), .CNT_W(CNT_W), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .IssueValidIN(iv), .DirAIN(da), .DirBIN(db),
    .UsaAIN(ua), .UsaBIN(ub), .WriteRegIN(wr), .DirWriteIN(dw), .LatIN(lat),
    .StallExtIN(ext), .FlushIN(fl), .StallOUT(stall_o), .BubbleOUT(bubble_o),
    .StallCntOUT(scnt_o), .PendOUT(pend_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // A register is busy when its result is still more than zero cycles away.
  function automatic bit busy(input logic use_it, input logic [4:0] r);
    return use_it && (r != 5'd0) && (mcnt[r] > 0);
  endfunction

  function automatic bit model_hazard();
    return iv && !fl && (busy(ua, da) || busy(ub, db) || busy(wr, dw));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREGS; r++) mcnt[r] = 0;
      mstall = 0;
    end else begin
      bit h, go;
      h  = model_hazard();
      go = iv && !fl && !h && !ext;
      for (int r = 0; r < NREGS; r++) begin
        if (go && wr && (r == int'(dw)) && (r != 0)) mcnt[r] = int'(lat);
        else if (mcnt[r] > 0 && !ext) mcnt[r] = mcnt[r] - 1;
      end
      if (h && mstall < CNTMAX) mstall = mstall + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      bit h;
      logic [NREGS-1:0] p;
      h = model_hazard();
      for (int r = 0; r < NREGS; r++) p[r] = (mcnt[r] != 0);
      check("stall",  32'(stall_o),  32'(h || ext));
      check("bubble", 32'(bubble_o), 32'((h || fl) && !ext));
      check("stallcnt", 32'(scnt_o), 32'(mstall));
      check("pend", 32'(pend_o), 32'(p));
    end
  end

  task automatic drv(input logic i_iv, input logic i_fl, input logic i_ext,
                     input logic i_ua, input logic [4:0] i_da,
                     input logic i_ub, input logic [4:0] i_db,
                     input logic i_wr, input logic [4:0] i_dw, input logic [LAT_W-1:0] i_lat);
    @(posedge clk);
    #1;
    iv = i_iv; fl = i_fl; ext = i_ext; ua = i_ua; da = i_da;
    ub = i_ub; db = i_db; wr = i_wr; dw = i_dw; lat = i_lat;
    #1;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 5'd0, 0, 5'd0, 0, 5'd0, '0);
  endtask

  task automatic wr_reg(input logic [4:0] r, input logic [LAT_W-1:0] l);
    drv(1, 0, 0, 0, 5'd0, 0, 5'd0, 1, r, l);
  endtask

  task automatic rd_a(input logic [4:0] r);
    drv(1, 0, 0, 1, r, 0, 5'd0, 0, 5'd0, '0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    iv = 0; fl = 0; ext = 0; ua = 0; ub = 0; wr = 0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #2;
    check("reset_pend",   32'(pend_o),   32'd0);
    check("reset_cnt",    32'(scnt_o),   32'd0);
    check("reset_stall",  32'(stall_o),  32'd0);
    check("reset_bubble", 32'(bubble_o), 32'd0);
    rst = 1'b0;

    // Load-use with a 2-cycle producer: two stall cycles, then issue.
    wr_reg(5'd5, 2'd2);
    rd_a(5'd5);
    check("lu2_stall0",  32'(stall_o),  32'd1);
    check("lu2_bubble0", 32'(bubble_o), 32'd1);
    rd_a(5'd5);
    check("lu2_stall1", 32'(stall_o), 32'd1);
    rd_a(5'd5);
    check("lu2_issue", 32'(stall_o), 32'd0);
    idle();
    check("lu2_cnt", 32'(scnt_o), 32'd2);

    // Load-use with a 1-cycle producer: reader issues the 2nd cycle after it.
    do_reset();
    wr_reg(5'd5, 2'd1);
    rd_a(5'd5);
    check("lu1_stall", 32'(stall_o), 32'd1);
    rd_a(5'd5);
    check("lu1_issue", 32'(stall_o), 32'd0);
    idle();
    check("lu1_cnt", 32'(scnt_o), 32'd1);

    // Independent stream: sliding window of three pending registers.
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      drv(1, 0, 0, 1, 5'd20, 1, 5'd21, 1, 5'(k), 2'd3);
      check("ind_nostall", 32'(stall_o), 32'd0);
    end
    idle();
    check("ind_window", 32'(pend_o), 32'h0000_01C0);

    // WAW held by an external stall, then by the countdown.
    do_reset();
    wr_reg(5'd7, 2'd3);
    idle();
    for (int k = 0; k < 2; k++) begin
      drv(1, 0, 1, 0, 5'd0, 0, 5'd0, 1, 5'd7, 2'd2);
      check("waw_ext_stall",  32'(stall_o),  32'd1);
      check("waw_ext_bubble", 32'(bubble_o), 32'd0);
    end
    for (int k = 0; k < 2; k++) begin
      drv(1, 0, 0, 0, 5'd0, 0, 5'd0, 1, 5'd7, 2'd2);
      check("waw_stall", 32'(stall_o), 32'd1);
    end
    drv(1, 0, 0, 0, 5'd0, 0, 5'd0, 1, 5'd7, 2'd2);
    check("waw_issue", 32'(stall_o), 32'd0);
    idle();
    check("waw_pend", 32'(pend_o), 32'h0000_0080);
    check("waw_cnt",  32'(scnt_o), 32'd4);

    // Register 0 is never tracked; a flushed hazard only bubbles.
    do_reset();
    wr_reg(5'd0, 2'd3);
    rd_a(5'd0);
    check("r0_nostall", 32'(stall_o), 32'd0);
    wr_reg(5'd12, 2'd3);
    drv(1, 1, 0, 1, 5'd12, 0, 5'd0, 0, 5'd0, '0);
    check("flush_stall",  32'(stall_o),  32'd0);
    check("flush_bubble", 32'(bubble_o), 32'd1);
    idle();
    check("flush_pend", 32'(pend_o), 32'h0000_1000);
    check("flush_cnt",  32'(scnt_o), 32'd0);

    // Asynchronous reset between edges drops every pending entry at once.
    do_reset();
    wr_reg(5'd9, 2'd3);
    wr_reg(5'd3, 2'd3);
    idle();
    check("pre_rst_pend", 32'(pend_o), 32'h0000_0208);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_pend", 32'(pend_o), 32'd0);
    #1;
    rst = 1'b0;
    rd_a(5'd3);
    check("post_rst_stall", 32'(stall_o), 32'd0);
    idle();
    check("post_rst_cnt", 32'(scnt_o), 32'd0);

    // Saturation: 7 rounds of 3 stall cycles = 21 hazard cycles.
    do_reset();
    for (int k = 0; k < 7; k++) begin
      wr_reg(5'd10, 2'd3);
      for (int j = 0; j < 4; j++) rd_a(5'd10);
    end
    idle();
    check("sat_cnt", 32'(scnt_o), 32'd15);
    rd_a(5'd10);
    idle();
    check("sat_hold", 32'(scnt_o), 32'd15);

    idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
